washer_ctrl_param: RTL and testbench
====================================

Name: washer_ctrl_param

Overview:
- Parametrised next-generation washing-machine controller; supersedes the fixed-timing washer FSM.
- Phase durations, rinse count and tick prescale are parameters; adds pause/resume, soap-wait timeout with fault, and multi-rinse sequencing.
- Sits between front-panel/sensor inputs and the valve, motor and door-lock drivers.

Parameters:
- CLK_PER_TICK, 4: clk cycles per timer tick (>=1).
- FILL_T, 3: ticks per fill phase, used for both wash fill and rinse fill (>=1).
- WASH_T, 5: ticks of wash agitation (>=1).
- DRAIN_T, 2: ticks per drain phase (>=1).
- RINSE_T, 3: ticks of rinse agitation (>=1).
- N_RINSE, 2: rinse cycles per program (1..15).
- SPIN_T, 4: ticks of spin/dry (>=1).
- SOAP_TO, 20: ticks waiting for soap before fault (>=1).
- TW, 8: timer_display width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- power  in  1  mains present
- program_selection  in  3  000 cold, 001 hot, 100 warm, 010 rinse+dry, 011 dry only; other codes invalid
- start  in  1  start request, sampled each clk
- pause  in  1  level; freezes a running program
- doorclosed  in  1  door sensor
- soap  in  1  detergent present
- valve_in_cold  out  1  cold inlet valve
- valve_in_hot  out  1  hot inlet valve
- valve_out  out  1  drain valve
- motor  out  2  00 off, 01 agitate, 10 spin, 11 never driven
- timer_display  out  TW  ticks remaining in current phase, saturated to all-ones
- program_done  out  1  program completed
- soap_warning  out  1  waiting for soap
- soap_in  out  1  detergent dispenser open
- lockDoor  out  1  door locked
- fault  out  1  soap timeout; cleared by next accepted start

Behaviour:
- Reset (rst=0): state IDLE; all outputs 0; latched program 000; rinse count 0; prescaler 0.
- Moore outputs: decoded from registered state and latched program only.
- States: IDLE, SOAP_WAIT, FILL, WASH, DRAIN, RFILL, RINSE, RDRAIN, SPIN, DONE, PAUSE.
- Start acceptance:
  - Accepted in IDLE or DONE when start=1, doorclosed=1, power=1 and program_selection is valid.
  - On the accepting edge: latch the program, clear fault and program_done, and enter the first phase.
  - Invalid code or open door: start ignored.
  - start while running: ignored, and the latched program is not changed.
- Sequences:
  - Wash programs (cold/hot/warm): SOAP_WAIT (skipped if soap=1 at accept) -> FILL -> WASH -> DRAIN -> {RFILL -> RINSE -> RDRAIN} x N_RINSE -> SPIN -> DONE.
  - Rinse+dry: the {RFILL, RINSE, RDRAIN} x N_RINSE block -> SPIN -> DONE.
  - Dry only: SPIN -> DONE.
- Phase timing:
  - On phase entry, load the phase counter with its duration and clear the prescaler.
  - Each tick (every CLK_PER_TICK cycles) decrements the counter.
  - The phase exits on the tick that takes the counter 1 -> 0, so each phase lasts exactly duration x CLK_PER_TICK cycles.
  - timer_display shows the counter value.
- SOAP_WAIT:
  - soap_warning=1.
  - soap=1 -> FILL on the next edge.
  - No soap for SOAP_TO ticks -> IDLE with fault=1.
- Outputs per state:
  - FILL: cold prog valve_in_cold=1; hot prog valve_in_hot=1; warm prog both=1. soap_in=1.
  - RFILL: valve_in_cold only.
  - WASH and RINSE: motor=01.
  - DRAIN and RDRAIN: valve_out=1.
  - SPIN: motor=10 and valve_out=1.
- lockDoor=1 in every state except IDLE and DONE.
- doorclosed is ignored while locked.
- DONE: program_done=1; timer_display=0; held until the next accepted start.
- Pause:
  - pause=1 in any running state -> PAUSE. The return state, counter and prescaler are frozen.
  - In PAUSE: valves and motor off, lockDoor=1, timer_display frozen.
  - pause=0 -> resume the saved state with its remaining time.
  - pause=1 in IDLE or DONE: no effect.
- Power loss:
  - power=0 in any state -> IDLE on the next edge. Program lost; fault unchanged.
  - Power loss takes priority over pause, tick and start.
- Simultaneous events:
  - soap going to 1 on the timeout tick: soap wins, go to FILL.
  - pause on a phase-ending tick: pause wins, and the phase stays at counter 1 with the prescaler frozen.

Decomposition:
- Shared header washer_defs.vh:
  - state encodings
  - program codes
  - motor codes
- Sub-module tick_prescaler: parameter CLK_PER_TICK; inputs clr and en; output tick.

Test Plan:
All scenarios use the default parameters.
- Cold, soap=1 at start:
  - Phases are 3,5,2,(3,3,2)x2,4 ticks = 30 ticks.
  - program_done rises exactly 120 clk after the accepting edge.
  - valve_in_cold is high for the first 12 cycles; valve_in_hot is never high.
- Hot, soap=0 at start, soap=1 after 40 cycles:
  - soap_warning is high for 40 cycles.
  - Then FILL asserts valve_in_hot=1 and soap_in=1.
  - fault stays 0.
- Warm, soap never supplied:
  - fault=1 and state IDLE after 80 cycles.
  - lockDoor is 0 afterwards.
  - A valid start clears fault.
- Dry only with pause:
  - Assert pause for 50 cycles mid-SPIN.
  - motor goes 10 -> 00 -> 10 and timer_display is frozen during the pause.
  - Completion is delayed by exactly 50 cycles.
- Interrupts during a running program:
  - power=0 mid-WASH -> next edge all outputs 0 and state IDLE.
  - A start with code 111 or doorclosed=0 is ignored and outputs stay 0.
- Asynchronous reset:
  - Assert rst=0 mid-RINSE, between clk edges.
  - All outputs are 0 immediately, before any clk edge.
  - Rinse count restarts from zero on the next program.

Source files
------------

// File: rtl/washer_ctrl_param_pkg.sv
// Shared state, program and motor encodings for the parametrised washer controller.
package washer_ctrl_param_pkg;

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StSoapWait = 4'd1,
      StFill     = 4'd2,
      StWash     = 4'd3,
      StDrain    = 4'd4,
      StRfill    = 4'd5,
      StRinse    = 4'd6,
      StRdrain   = 4'd7,
      StSpin     = 4'd8,
      StDone     = 4'd9,
      StPause    = 4'd10
   } state_t;

   localparam logic [2:0] ProgCold     = 3'b000;
   localparam logic [2:0] ProgHot      = 3'b001;
   localparam logic [2:0] ProgWarm     = 3'b100;
   localparam logic [2:0] ProgRinseDry = 3'b010;
   localparam logic [2:0] ProgDryOnly  = 3'b011;

   localparam logic [1:0] MotorOff     = 2'b00;
   localparam logic [1:0] MotorAgitate = 2'b01;
   localparam logic [1:0] MotorSpin    = 2'b10;

   function automatic logic prog_valid(input logic [2:0] code);
      return code inside {ProgCold, ProgHot, ProgWarm, ProgRinseDry, ProgDryOnly};
   endfunction

endpackage

// File: rtl/washer_ctrl_param_tick_prescaler.sv
// Divides clk into one-cycle timer ticks; clr restarts the division, en freezes it when low.
module washer_ctrl_param_tick_prescaler #(
   parameter int unsigned CLK_PER_TICK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(CLK_PER_TICK - 1);

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == LastCnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/washer_ctrl_param.sv
// Parametrised washing-machine controller: phase sequencing, pause/resume and soap timeout.
module washer_ctrl_param
   import washer_ctrl_param_pkg::*;
#(
   parameter int unsigned CLK_PER_TICK = 4,
   parameter int unsigned FILL_T       = 3,
   parameter int unsigned WASH_T       = 5,
   parameter int unsigned DRAIN_T      = 2,
   parameter int unsigned RINSE_T      = 3,
   parameter int unsigned N_RINSE      = 2,
   parameter int unsigned SPIN_T       = 4,
   parameter int unsigned SOAP_TO      = 20,
   parameter int unsigned TW           = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          power,
   input  logic [2:0]    program_selection,
   input  logic          start,
   input  logic          pause,
   input  logic          doorclosed,
   input  logic          soap,
   output logic          valve_in_cold,
   output logic          valve_in_hot,
   output logic          valve_out,
   output logic [1:0]    motor,
   output logic [TW-1:0] timer_display,
   output logic          program_done,
   output logic          soap_warning,
   output logic          soap_in,
   output logic          lockDoor,
   output logic          fault
);

   localparam logic [31:0] DispMax   = (TW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << TW) - 32'd1);
   localparam logic [3:0]  RinseLast = 4'(N_RINSE - 1);

   state_t      r_state, r_ret;
   logic [2:0]  r_prog;
   logic [31:0] r_cnt;
   logic [3:0]  r_rinse;
   logic        r_fault;

   state_t      w_state_next, w_ret_next, w_enter_st, w_eff_state;
   logic [2:0]  w_prog_next;
   logic [31:0] w_cnt_next;
   logic [3:0]  w_rinse_next;
   logic        w_fault_next;
   logic        w_enter;
   logic        w_ps_en;
   logic        w_tick;
   logic [TW-1:0] w_disp;

   function automatic logic [31:0] phase_ticks(input state_t st);
      case (st)
         StSoapWait:      return 32'(SOAP_TO);
         StFill, StRfill: return 32'(FILL_T);
         StWash:          return 32'(WASH_T);
         StDrain,
         StRdrain:        return 32'(DRAIN_T);
         StRinse:         return 32'(RINSE_T);
         StSpin:          return 32'(SPIN_T);
         default:         return 32'd0;
      endcase
   endfunction

   washer_ctrl_param_tick_prescaler #(
      .CLK_PER_TICK (CLK_PER_TICK)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_enter),
      .en   (w_ps_en),
      .tick (w_tick)
   );

   // While paused, a deasserted pause resumes and counts on the same edge as the saved phase.
   assign w_eff_state = (r_state == StPause) ? r_ret : r_state;

   always_comb begin
      w_state_next = r_state;
      w_ret_next   = r_ret;
      w_prog_next  = r_prog;
      w_cnt_next   = r_cnt;
      w_rinse_next = r_rinse;
      w_fault_next = r_fault;
      w_ps_en      = 1'b0;
      w_enter      = 1'b0;
      w_enter_st   = StIdle;

      if (!power) begin
         w_prog_next  = ProgCold;
         w_rinse_next = '0;
         w_enter      = 1'b1;
         w_enter_st   = StIdle;
      end else if (r_state == StIdle || r_state == StDone) begin
         if (start && doorclosed && prog_valid(program_selection)) begin
            w_prog_next  = program_selection;
            w_rinse_next = '0;
            w_fault_next = 1'b0;
            w_enter      = 1'b1;
            case (program_selection)
               ProgRinseDry: w_enter_st = StRfill;
               ProgDryOnly:  w_enter_st = StSpin;
               default:      w_enter_st = soap ? StFill : StSoapWait;
            endcase
         end
      end else if (pause) begin
         if (r_state != StPause) begin
            w_ret_next   = r_state;
            w_state_next = StPause;
         end
      end else begin
         w_state_next = w_eff_state;
         w_ps_en      = 1'b1;
         if (w_eff_state == StSoapWait && soap) begin
            w_enter    = 1'b1;
            w_enter_st = StFill;
         end else if (w_tick) begin
            if (r_cnt > 32'd1) begin
               w_cnt_next = r_cnt - 32'd1;
            end else begin
               w_enter = 1'b1;
               case (w_eff_state)
                  StSoapWait: begin
                     w_enter_st   = StIdle;
                     w_fault_next = 1'b1;
                  end
                  StFill:   w_enter_st = StWash;
                  StWash:   w_enter_st = StDrain;
                  StDrain:  w_enter_st = StRfill;
                  StRfill:  w_enter_st = StRinse;
                  StRinse:  w_enter_st = StRdrain;
                  StRdrain: begin
                     if (r_rinse == RinseLast) begin
                        w_enter_st = StSpin;
                     end else begin
                        w_enter_st   = StRfill;
                        w_rinse_next = r_rinse + 4'd1;
                     end
                  end
                  StSpin:   w_enter_st = StDone;
                  default:  w_enter_st = StIdle;
               endcase
            end
         end
      end

      if (w_enter) begin
         w_state_next = w_enter_st;
         w_cnt_next   = phase_ticks(w_enter_st);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_ret   <= StIdle;
         r_prog  <= ProgCold;
         r_cnt   <= '0;
         r_rinse <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ret   <= w_ret_next;
         r_prog  <= w_prog_next;
         r_cnt   <= w_cnt_next;
         r_rinse <= w_rinse_next;
         r_fault <= w_fault_next;
      end
   end

   assign w_disp = (r_cnt > DispMax) ? '1 : r_cnt[TW-1:0];
   assign fault  = r_fault;

   always_comb begin
      valve_in_cold = 1'b0;
      valve_in_hot  = 1'b0;
      valve_out     = 1'b0;
      motor         = MotorOff;
      program_done  = 1'b0;
      soap_warning  = 1'b0;
      soap_in       = 1'b0;
      lockDoor      = 1'b1;
      timer_display = w_disp;
      case (r_state)
         StIdle: begin
            lockDoor      = 1'b0;
            timer_display = '0;
         end
         StDone: begin
            lockDoor      = 1'b0;
            timer_display = '0;
            program_done  = 1'b1;
         end
         StSoapWait: soap_warning = 1'b1;
         StFill: begin
            valve_in_cold = (r_prog == ProgCold) || (r_prog == ProgWarm);
            valve_in_hot  = (r_prog == ProgHot) || (r_prog == ProgWarm);
            soap_in       = 1'b1;
         end
         StRfill:          valve_in_cold = 1'b1;
         StWash, StRinse:  motor = MotorAgitate;
         StDrain, StRdrain: valve_out = 1'b1;
         StSpin: begin
            motor     = MotorSpin;
            valve_out = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_washer_ctrl_param.sv
// Self-checking bench: start-decode table, directed multi-cycle scenarios, random vs phase model.
module tb_washer_ctrl_param;

   localparam int CPT = 4, FILL_T = 3, WASH_T = 5, DRAIN_T = 2, RINSE_T = 3;
   localparam int N_RINSE = 2, SPIN_T = 4, SOAP_TO = 20;
   localparam int KSoap = 0, KFill = 1, KWash = 2, KDrain = 3, KRfill = 4, KRinse = 5;
   localparam int KRdrain = 6, KSpin = 7;
   localparam int MIdle = 0, MRun = 1, MDone = 2;

   logic       clk = 1'b0, rst = 1'b0, power = 1'b0, start = 1'b0, pause = 1'b0;
   logic       doorclosed = 1'b0, soap = 1'b0;
   logic [2:0] program_selection = 3'b000;
   logic       valve_in_cold, valve_in_hot, valve_out, program_done, soap_warning;
   logic       soap_in, lockDoor, fault;
   logic [1:0] motor;
   logic [7:0] timer_display;
   logic [17:0] w_vec;

   int n_checks = 0, n_pass = 0, cyc = 0;

   always #5 clk = ~clk;

   washer_ctrl_param #(
      .CLK_PER_TICK (4), .FILL_T (3), .WASH_T (5), .DRAIN_T (2), .RINSE_T (3),
      .N_RINSE (2), .SPIN_T (4), .SOAP_TO (20), .TW (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .power             (power),
      .program_selection (program_selection),
      .start             (start),
      .pause             (pause),
      .doorclosed        (doorclosed),
      .soap              (soap),
      .valve_in_cold     (valve_in_cold),
      .valve_in_hot      (valve_in_hot),
      .valve_out         (valve_out),
      .motor             (motor),
      .timer_display     (timer_display),
      .program_done      (program_done),
      .soap_warning      (soap_warning),
      .soap_in           (soap_in),
      .lockDoor          (lockDoor),
      .fault             (fault)
   );

   assign w_vec = {valve_in_cold, valve_in_hot, valve_out, motor, program_done, soap_warning,
                   soap_in, lockDoor, fault, timer_display};

   function automatic logic [17:0] pack(input int c, input int h, input int o, input int m,
                                        input int d, input int w, input int si, input int l,
                                        input int f, input int t);
      return {c[0], h[0], o[0], m[1:0], d[0], w[0], si[0], l[0], f[0], t[7:0]};
   endfunction

   task automatic check_vec(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %05h want %05h (cyc %0d)", name, act, exp, cyc);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      rst = 1'b1;
      power = 1'b1;
      pause = 1'b0;
      start = 1'b0;
      step();
   endtask

   task automatic apply_start(input logic [2:0] sel, input logic door, output int ca);
      program_selection = sel;
      doorclosed = door;
      start = 1'b1;
      step();
      start = 1'b0;
      doorclosed = 1'b1;
      ca = cyc;
   endtask

   task automatic wait_done(input int ca, input int max, output int n);
      n = -1;
      for (int k = 1; k <= max && n < 0; k++) begin
         step();
         if (program_done === 1'b1) n = cyc - ca;
      end
   endtask

   // ---------------- reference model: queue of phases and elapsed cycles ----------------
   int         m_q[$];
   int         m_mode = MIdle, m_el = 0;
   bit         m_paused = 1'b0, m_fault = 1'b0;
   logic [2:0] m_prog = 3'b000;

   function automatic int kind_ticks(input int k);
      case (k)
         KSoap:           return SOAP_TO;
         KFill, KRfill:   return FILL_T;
         KWash:           return WASH_T;
         KDrain, KRdrain: return DRAIN_T;
         KRinse:          return RINSE_T;
         default:         return SPIN_T;
      endcase
   endfunction

   function automatic void model_step(input logic pw, input logic st, input logic [2:0] sel,
                                      input logic pa, input logic dc, input logic sp);
      bit wash, valid;
      wash  = (sel == 3'b000) || (sel == 3'b001) || (sel == 3'b100);
      valid = wash || (sel == 3'b010) || (sel == 3'b011);
      if (!pw) begin
         m_mode = MIdle;
         m_q.delete();
         m_paused = 1'b0;
         m_prog = 3'b000;
      end else if (m_mode != MRun) begin
         if (st && dc && valid) begin
            m_q.delete();
            if (wash) begin
               if (!sp) m_q.push_back(KSoap);
               m_q.push_back(KFill);
               m_q.push_back(KWash);
               m_q.push_back(KDrain);
            end
            if (sel != 3'b011) begin
               for (int r = 0; r < N_RINSE; r++) begin
                  m_q.push_back(KRfill);
                  m_q.push_back(KRinse);
                  m_q.push_back(KRdrain);
               end
            end
            m_q.push_back(KSpin);
            m_prog = sel;
            m_fault = 1'b0;
            m_mode = MRun;
            m_el = 0;
            m_paused = 1'b0;
         end
      end else if (pa) begin
         m_paused = 1'b1;
      end else begin
         m_paused = 1'b0;
         if (m_q[0] == KSoap && sp) begin
            void'(m_q.pop_front());
            m_el = 0;
         end else begin
            m_el++;
            if (m_el == kind_ticks(m_q[0]) * CPT) begin
               if (m_q[0] == KSoap) begin
                  m_fault = 1'b1;
                  m_mode = MIdle;
                  m_q.delete();
               end else begin
                  void'(m_q.pop_front());
                  m_el = 0;
                  if (m_q.size() == 0) m_mode = MDone;
               end
            end
         end
      end
   endfunction

   function automatic logic [17:0] model_out();
      int rem, t, f, c, h;
      f = int'(m_fault);
      if (m_mode == MIdle) return pack(0, 0, 0, 0, 0, 0, 0, 0, f, 0);
      if (m_mode == MDone) return pack(0, 0, 0, 0, 1, 0, 0, 0, f, 0);
      rem = kind_ticks(m_q[0]) * CPT - m_el;
      t = (rem + CPT - 1) / CPT;
      if (t > 255) t = 255;
      if (m_paused) return pack(0, 0, 0, 0, 0, 0, 0, 1, f, t);
      c = int'(m_prog == 3'b000 || m_prog == 3'b100);
      h = int'(m_prog == 3'b001 || m_prog == 3'b100);
      case (m_q[0])
         KSoap:           return pack(0, 0, 0, 0, 0, 1, 0, 1, f, t);
         KFill:           return pack(c, h, 0, 0, 0, 0, 1, 1, f, t);
         KWash, KRinse:   return pack(0, 0, 0, 1, 0, 0, 0, 1, f, t);
         KDrain, KRdrain: return pack(0, 0, 1, 0, 0, 0, 0, 1, f, t);
         KRfill:          return pack(1, 0, 0, 0, 0, 0, 0, 1, f, t);
         default:         return pack(0, 0, 1, 2, 0, 0, 0, 1, f, t);
      endcase
   endfunction

   typedef struct {
      logic [2:0]  sel;
      logic        door;
      logic        soap;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ca, n, bad, cnt, hot_seen, pwr_left, pause_left;

      tbl[0] = '{3'b000, 1'b1, 1'b1, pack(1, 0, 0, 0, 0, 0, 1, 1, 0, 3)};
      tbl[1] = '{3'b001, 1'b1, 1'b1, pack(0, 1, 0, 0, 0, 0, 1, 1, 0, 3)};
      tbl[2] = '{3'b100, 1'b1, 1'b1, pack(1, 1, 0, 0, 0, 0, 1, 1, 0, 3)};
      tbl[3] = '{3'b001, 1'b1, 1'b0, pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 20)};
      tbl[4] = '{3'b010, 1'b1, 1'b0, pack(1, 0, 0, 0, 0, 0, 0, 1, 0, 3)};
      tbl[5] = '{3'b011, 1'b1, 1'b1, pack(0, 0, 1, 2, 0, 0, 0, 1, 0, 4)};
      tbl[6] = '{3'b111, 1'b1, 1'b1, 18'h0};
      tbl[7] = '{3'b101, 1'b1, 1'b1, 18'h0};
      tbl[8] = '{3'b110, 1'b1, 1'b1, 18'h0};
      tbl[9] = '{3'b000, 1'b0, 1'b1, 18'h0};

      #12;
      check_vec("reset_outputs", w_vec, 18'h0);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         do_reset();
         soap = tbl[i].soap;
         apply_start(tbl[i].sel, tbl[i].door, ca);
         check_vec($sformatf("start_table_%0d", i), w_vec, tbl[i].exp);
      end

      // Cold with soap present: fill is the first 12 cycles, whole program 120 cycles.
      do_reset();
      soap = 1'b1;
      apply_start(3'b000, 1'b1, ca);
      bad = 0;
      hot_seen = int'(valve_in_hot);
      if (!valve_in_cold) bad++;
      for (int k = 1; k < 12; k++) begin
         step();
         if (!valve_in_cold) bad++;
         if (valve_in_hot) hot_seen = 1;
      end
      check_int("cold_first12_cold_on", bad, 0);
      step();
      check_int("cold_fill_ends_at12", int'(valve_in_cold), 0);
      n = -1;
      for (int k = 13; k <= 200 && n < 0; k++) begin
         step();
         if (valve_in_hot) hot_seen = 1;
         if (program_done === 1'b1) n = cyc - ca;
      end
      check_int("cold_done_cycles", n, 120);
      check_int("cold_hot_never", hot_seen, 0);

      // Hot with late soap.
      do_reset();
      soap = 1'b0;
      apply_start(3'b001, 1'b1, ca);
      cnt = int'(soap_warning);
      for (int k = 1; k < 40; k++) begin
         step();
         cnt += int'(soap_warning);
      end
      soap = 1'b1;
      step();
      check_int("hot_soap_warning_cycles", cnt, 40);
      check_vec("hot_fill_outputs", w_vec, pack(0, 1, 0, 0, 0, 0, 1, 1, 0, 3));
      wait_done(ca, 300, n);
      check_int("hot_done_cycles", n, 160);
      check_int("hot_no_fault", int'(fault), 0);

      // Warm, soap never supplied: timeout at 80 cycles.
      do_reset();
      soap = 1'b0;
      apply_start(3'b100, 1'b1, ca);
      for (int k = 1; k < 80; k++) step();
      check_vec("warm_wait_79", w_vec, pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      step();
      check_vec("warm_timeout", w_vec, pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      soap = 1'b1;
      apply_start(3'b000, 1'b1, ca);
      check_int("warm_fault_cleared", int'(fault), 0);

      // Dry only, 50-cycle pause in SPIN.
      do_reset();
      apply_start(3'b011, 1'b1, ca);
      for (int k = 1; k <= 8; k++) step();
      check_vec("dry_before_pause", w_vec, pack(0, 0, 1, 2, 0, 0, 0, 1, 0, 2));
      pause = 1'b1;
      bad = 0;
      for (int k = 9; k <= 58; k++) begin
         step();
         if (w_vec !== pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 2)) bad++;
      end
      check_int("dry_pause_frozen_bad", bad, 0);
      pause = 1'b0;
      step();
      check_int("dry_resume_motor", int'(motor), 2);
      wait_done(ca, 200, n);
      check_int("dry_done_cycles", n, 66);

      // Power loss mid-WASH, then ignored starts.
      do_reset();
      soap = 1'b1;
      apply_start(3'b000, 1'b1, ca);
      for (int k = 1; k <= 20; k++) step();
      check_int("pwr_in_wash", int'(motor), 1);
      power = 1'b0;
      step();
      check_vec("pwr_off_outputs", w_vec, 18'h0);
      power = 1'b1;
      program_selection = 3'b111;
      doorclosed = 1'b1;
      start = 1'b1;
      step();
      check_vec("bad_code_ignored", w_vec, 18'h0);
      program_selection = 3'b000;
      doorclosed = 1'b0;
      step();
      check_vec("door_open_ignored", w_vec, 18'h0);
      start = 1'b0;
      doorclosed = 1'b1;

      // Asynchronous reset mid-RINSE.
      do_reset();
      apply_start(3'b010, 1'b1, ca);
      for (int k = 1; k <= 15; k++) step();
      check_int("rst_in_rinse", int'(motor), 1);
      #2;
      rst = 1'b0;
      #1;
      check_vec("async_reset_outputs", w_vec, 18'h0);
      @(negedge clk);
      rst = 1'b1;
      step();
      apply_start(3'b010, 1'b1, ca);
      wait_done(ca, 200, n);
      check_int("rinse_dry_after_reset", n, 80);

      // Random stimulus against the phase-queue model.
      do_reset();
      m_mode = MIdle;
      m_q.delete();
      m_paused = 1'b0;
      m_fault = 1'b0;
      m_prog = 3'b000;
      pwr_left = 0;
      pause_left = 0;
      soap = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (pwr_left > 0) pwr_left--;
         else if ($urandom_range(0, 1999) == 0) pwr_left = int'($urandom_range(1, 3));
         if (pause_left > 0) pause_left--;
         else if ($urandom_range(0, 149) == 0) pause_left = int'($urandom_range(1, 40));
         power = (pwr_left == 0);
         pause = (pause_left > 0);
         start = ($urandom_range(0, 15) == 0);
         program_selection = 3'($urandom_range(0, 7));
         doorclosed = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 59) == 0) soap = ~soap;
         model_step(power, start, program_selection, pause, doorclosed, soap);
         step();
         check_vec("random", w_vec, model_out());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
